instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage that produces the 32-bit `Instr` word consumed by the decode stage. It owns the program counter. It fetches one instruction at a time from instruction memory over a request/acknowledge handshake, holds the word stable with a valid flag until the control unit takes it, then advances the PC sequentially or to a branch target. A watchdog flags a memory that never acknowledges.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `TIMEOUT`, default 16: maximum cycles `mem_req` may stay high without `mem_ack` before a fault; legal range 1..255.

Ports:
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `mem_req`  out  1  fetch request to instruction memory.
- `mem_addr`  out  32  byte address of the request; always equals `PC`.
- `mem_ack`  in  1  one-cycle pulse; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  instruction word from memory.
- `Instr`  out  32  registered instruction word to decode.
- `Instr_valid`  out  1  `Instr` holds a fetched word not yet taken.
- `Instr_taken`  in  1  control consumes `Instr` this cycle; the same strobe as the PC load enable.
- `PC_sel`  in  1  sampled with `Instr_taken`: 0 selects PC+4, 1 selects branch.
- `PC_Immed`  in  32  branch offset, already sign-extended and shifted by the immediate converter; sampled with `Instr_taken`.
- `PC`  out  32  address of the instruction currently fetched or held.
- `Fetch_err`  out  1  sticky watchdog fault.

## Operation

States:
- **FETCH**
  - `mem_req`=1, `mem_addr`=`PC`.
  - On `mem_ack`: `Instr` <= `mem_rdata`, `Instr_valid` <= 1, go to HOLD.
  - When the wait counter reaches `TIMEOUT` without `mem_ack`: `Fetch_err` <= 1, go to HALT.
- **HOLD**
  - `mem_req`=0; `Instr`, `Instr_valid`=1 and `PC` are stable.
  - On `Instr_taken`:
    - `Instr_valid` <= 0.
    - `PC` <= `PC_sel` ? (PC + 4 + `PC_Immed`) : (PC + 4).
    - Go to FETCH.
- **HALT**
  - `mem_req`=0, `Instr_valid`=0, `Fetch_err`=1.
  - Left only by `Reset`.

Arithmetic and width rules:
- The PC adder is 32-bit and wraps mod 2^32 with no overflow flag.
- The next PC has bits [1:0] forced to 0.

Watchdog counter:
- 8-bit counter, cleared on entry to FETCH.
- Increments each FETCH cycle without `mem_ack`.
- The fault fires on the cycle the count equals `TIMEOUT` and `mem_ack` is low.
- A `mem_ack` in that same cycle wins: the word is captured and no fault is raised.

Input handling outside the handshake:
- `Instr_taken` is ignored unless the state is HOLD; `PC_sel` and `PC_Immed` are don't-care then.
- `mem_ack` is ignored outside FETCH. A stray ack must not change `Instr`.

Reset (asynchronous, any state, mid-request included):
- State = FETCH, `PC` = `RESET_PC`, `Instr` = 0, `Instr_valid` = 0, `Fetch_err` = 0, counter = 0.
- `mem_req` is forced to 0 while `Reset` is high.
- `mem_req` rises in the first cycle after deassertion.

## Timing

- `mem_req` and `mem_addr` are combinational from the state register and `PC`; all other outputs are registered.
- Memory acknowledging in the first request cycle gives the fastest throughput of one instruction per 2 cycles:
  - Cycle t: HOLD with `Instr_taken`=1.
  - Cycle t+1: FETCH with ack.
  - Cycle t+2: HOLD with new `Instr`.
- Fetch latency is 1 + N cycles from entering FETCH to `Instr_valid`, where N is the memory wait (0..`TIMEOUT`-1).
- `PC` updates on the same edge that clears `Instr_valid`. `mem_addr` therefore shows the new PC in the first FETCH cycle.
- The memory side must hold `mem_rdata` only during the ack cycle. `Instr` is captured on that edge.

## Test plan

- **Reset and sequential fetch:**
  - Stimulus: `Reset` pulse with `RESET_PC`=0; memory acks in the first cycle with words A, B, C; `Instr_taken` pulsed each HOLD with `PC_sel`=0.
  - Required: `mem_addr` reads 0, 4, 8; `Instr` reads A, B, C; `Instr_valid` high one cycle in every two.
- **Branch redirect:**
  - Stimulus: PC=0x10, take with `PC_sel`=1, `PC_Immed`=0xFFFF_FFF0.
  - Required: next `mem_addr`=0x04.
- **Wrap and alignment:**
  - Stimulus 1: PC=0xFFFF_FFFC, sequential take. Required: PC=0x0000_0000.
  - Stimulus 2: branch with `PC_Immed`=0x6. Required: target bits [1:0]=0.
- **Wait states and stray handshake:**
  - Stimulus: memory acks after 3 wait cycles; `Instr_taken` and `mem_ack` pulsed during HOLD.
  - Required: `Instr_valid` 4 cycles after FETCH entry; `Instr` and `PC` unchanged by the stray pulses.
- **Watchdog:**
  - Stimulus 1: `TIMEOUT`=4, memory never acks. Required: `Fetch_err`=1 and `mem_req`=0 after 4 cycles; stays there until `Reset`.
  - Stimulus 2: ack on exactly the 4th count. Required: word captured, no fault.
- **Reset mid-operation:**
  - Stimulus: assert `Reset` asynchronously during a FETCH wait and during HOLD.
  - Required: outputs return to reset values immediately; the fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and fetches one instruction at a time over a
// request/ack handshake, holding it for decode; a watchdog traps a dead memory.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] Instr,
   output logic        Instr_valid,
   input  logic        Instr_taken,
   input  logic        PC_sel,
   input  logic [31:0] PC_Immed,
   output logic [31:0] PC,
   output logic        Fetch_err
);

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      HALT
   } state_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  wait_cnt;
   logic        timeout;
   logic        capture;
   logic        advance;
   logic [31:0] pc_sum;
   logic [31:0] pc_nxt;

   // wait_cnt holds completed unacked cycles, so the TIMEOUT-th
   // request cycle is the last one in which an ack is still accepted.
   assign timeout  = (state == FETCH) && !mem_ack
                     && (wait_cnt == LAST_WAIT);
   assign capture  = (state == FETCH) && mem_ack;
   assign advance  = (state == HOLD) && Instr_taken;

   assign pc_sum   = PC + 32'd4 + (PC_sel ? PC_Immed : 32'd0);
   assign pc_nxt   = {pc_sum[31:2], 2'b00};

   assign mem_req  = (state == FETCH) && !Reset;
   assign mem_addr = PC;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         FETCH: begin
            if (capture) begin
               state_nxt = HOLD;
            end else if (timeout) begin
               state_nxt = HALT;
            end
         end
         HOLD: begin
            if (advance) begin
               state_nxt = FETCH;
            end
         end
         HALT: begin
            state_nxt = HALT;
         end
         default: begin
            state_nxt = HALT;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         PC          <= RESET_PC;
         Instr       <= 32'd0;
         Instr_valid <= 1'b0;
         Fetch_err   <= 1'b0;
         wait_cnt    <= 8'd0;
      end else begin
         if (capture) begin
            Instr       <= mem_rdata;
            Instr_valid <= 1'b1;
         end
         if (advance) begin
            Instr_valid <= 1'b0;
            PC          <= pc_nxt;
         end
         if (timeout) begin
            Fetch_err <= 1'b1;
         end
         if (advance) begin
            wait_cnt <= 8'd0;
         end else if ((state == FETCH) && !mem_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end

endmodule
